crypt_share_scheduler: RTL and testbench

CRYPT_SHARE_SCHEDULER -- requirements
Module: crypt_share_scheduler

---
 rtl/encrypt_config.sv | 45 ++++
 rtl/crypt_rr_arbiter.sv | 54 +++++
 rtl/crypt_share_scheduler.sv | 161 ++++++++++++++++
 tb/tb_crypt_share_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/encrypt_config.sv
// ============================================================================
// Package     : encrypt_config
// Description : Shared constants and types for the crypt share scheduler.
//               Holds the three rotating XOR keys, the requester and key
//               index types, the in-flight tag record, and the helpers that
//               map a key index to its key and advance the index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package encrypt_config;

   localparam logic [7:0] XOR_KEY1 = 8'hA5;
   localparam logic [7:0] XOR_KEY2 = 8'h5A;
   localparam logic [7:0] XOR_KEY3 = 8'hC3;

   localparam int NUM_KEYS = 3;

   typedef logic       req_id_t;
   typedef logic [1:0] key_idx_t;

   // Owner record carried alongside each byte in the shared datapath
   typedef struct packed {
      logic    vld;
      req_id_t owner;
   } tag_t;

   function automatic logic [7:0] key_of(input key_idx_t idx);
      logic [7:0] key;
      case (idx)
         2'd1:    key = XOR_KEY2;
         2'd2:    key = XOR_KEY3;
         default: key = XOR_KEY1;
      endcase
      return key;
   endfunction

   // Rotate 0 -> 1 -> 2 -> 0
   function automatic key_idx_t next_idx(input key_idx_t idx);
      return (idx == key_idx_t'(NUM_KEYS - 1)) ? key_idx_t'(0) : idx + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/crypt_rr_arbiter.sv
// ============================================================================
// Module      : crypt_rr_arbiter
// Description : Two-requester arbiter for the shared XOR datapath.
//               Default build: round-robin, the pointer owner wins a
//               conflict and the pointer moves to the other requester after
//               every grant. With CRYPT_SCHED_FIXED_PRIO_EN defined,
//               requester 0 always wins and no pointer exists.
// Ports       : clk   - clock
//               rst   - asynchronous active-high reset
//               req_i - request vector {req1, req0}
//               gnt_o - combinational grant vector, forced 0 during reset
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypt_rr_arbiter
   import encrypt_config::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic [1:0] w_gnt;

`ifdef CRYPT_SCHED_FIXED_PRIO_EN
   // Strict priority has no state, so the clock is not needed here
   logic w_unused_clk;
   assign w_unused_clk = clk;

   assign w_gnt = {req_i[1] & ~req_i[0], req_i[0]};
`else
   req_id_t ptr_q;

   assign w_gnt[0] = req_i[0] & (~req_i[1] | (ptr_q == 1'b0));
   assign w_gnt[1] = req_i[1] & (~req_i[0] | (ptr_q == 1'b1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else if (w_gnt[0]) begin
         ptr_q <= 1'b1;
      end else if (w_gnt[1]) begin
         ptr_q <= 1'b0;
      end
   end
`endif

   assign gnt_o = w_gnt & {2{~rst}};

endmodule

`default_nettype wire

// File: rtl/crypt_share_scheduler.sv
// ============================================================================
// Module      : crypt_share_scheduler
// Description : Shares one external XOR datapath between two requesters.
//               Accepts one byte per clock, attaches a per-requester rotating
//               key, tracks ownership of in-flight bytes and steers results
//               back to the owner. Flags sticky protocol errors when result
//               valids and tracked tags disagree.
//               Macro CRYPT_SCHED_FIXED_PRIO_EN selects strict priority
//               (requester 0 wins) in place of round-robin arbitration.
// Ports       : clk, rst               - clock, async active-high reset
//               req0/1, din0/1         - requester byte offers
//               key_clr0/1             - restart requester key rotation
//               gnt0/1                 - combinational accept
//               crypt_en/din/key       - registered datapath drive
//               crypt_v/dout           - datapath result
//               v0/1, dout0/1          - registered result to the owner
//               err                    - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypt_share_scheduler
   import encrypt_config::*;
#(
   parameter int LATENCY = 2
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] din0,
   input  logic [7:0] din1,
   input  logic       key_clr0,
   input  logic       key_clr1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       crypt_en,
   output logic [7:0] crypt_din,
   output logic [7:0] crypt_key,
   input  logic       crypt_v,
   input  logic [7:0] crypt_dout,
   output logic       v0,
   output logic       v1,
   output logic [7:0] dout0,
   output logic [7:0] dout1,
   output logic       err
);

   logic [1:0] w_gnt;
   req_id_t    w_sel;
   logic [7:0] w_din;
   logic [7:0] w_key;
   logic       w_clr;
   key_idx_t   w_idx;
   key_idx_t   idx0_d, idx1_d;
   key_idx_t   idx0_q, idx1_q;
   logic       crypt_en_q;
   logic [7:0] crypt_din_q, crypt_key_q;
   req_id_t    owner_q;
   tag_t       tag_q [0:LATENCY];
   tag_t       w_head;
   logic       v0_d, v1_d;
   logic       v0_q, v1_q;
   logic [7:0] dout0_q, dout1_q;
   logic       err_q;

   crypt_rr_arbiter u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i ({req1, req0}),
      .gnt_o (w_gnt)
   );

   assign gnt0 = w_gnt[0];
   assign gnt1 = w_gnt[1];

   always_comb begin
      w_sel = w_gnt[1];
      w_din = w_sel ? din1     : din0;
      w_clr = w_sel ? key_clr1 : key_clr0;
      w_idx = w_sel ? idx1_q   : idx0_q;
      // A clear coinciding with a grant uses KEY1 now and KEY2 next
      w_key = w_clr ? XOR_KEY1 : key_of(w_idx);

      idx0_d = idx0_q;
      if (w_gnt[0]) begin
         idx0_d = key_clr0 ? key_idx_t'(1) : next_idx(idx0_q);
      end else if (key_clr0) begin
         idx0_d = key_idx_t'(0);
      end

      idx1_d = idx1_q;
      if (w_gnt[1]) begin
         idx1_d = key_clr1 ? key_idx_t'(1) : next_idx(idx1_q);
      end else if (key_clr1) begin
         idx1_d = key_idx_t'(0);
      end
   end

   // The tag line starts alongside the datapath's own input register, so
   // the head lines up with crypt_v for the same byte.
   assign w_head = tag_q[LATENCY];
   assign v0_d   = crypt_v & w_head.vld & (w_head.owner == 1'b0);
   assign v1_d   = crypt_v & w_head.vld & (w_head.owner == 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crypt_en_q  <= 1'b0;
         crypt_din_q <= '0;
         crypt_key_q <= '0;
         owner_q     <= 1'b0;
         idx0_q      <= '0;
         idx1_q      <= '0;
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         dout0_q     <= '0;
         dout1_q     <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i <= LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         crypt_en_q <= |w_gnt;
         if (|w_gnt) begin
            crypt_din_q <= w_din;
            crypt_key_q <= w_key;
            owner_q     <= w_sel;
         end
         tag_q[0] <= '{vld: crypt_en_q, owner: owner_q};
         for (int i = 1; i <= LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         idx0_q <= idx0_d;
         idx1_q <= idx1_d;
         v0_q   <= v0_d;
         v1_q   <= v1_d;
         if (v0_d) begin
            dout0_q <= crypt_dout;
         end
         if (v1_d) begin
            dout1_q <= crypt_dout;
         end
         if (crypt_v != w_head.vld) begin
            err_q <= 1'b1;
         end
      end
   end

   assign crypt_en  = crypt_en_q;
   assign crypt_din = crypt_din_q;
   assign crypt_key = crypt_key_q;
   assign v0        = v0_q;
   assign v1        = v1_q;
   assign dout0     = dout0_q;
   assign dout1     = dout1_q;
   assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_crypt_share_scheduler.sv
// ============================================================================
// Module      : tb_crypt_share_scheduler
// Description : Directed bench for crypt_share_scheduler with a behavioural
//               XOR datapath model. Honours CRYPT_SCHED_FIXED_PRIO_EN to pick
//               the arbitration scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package test_utils;
   function automatic logic [7:0] decrypt(input logic [7:0] data, input logic [7:0] key);
      return data ^ key;
   endfunction
endpackage

module tb_crypt_share_scheduler;

   localparam int LAT = 2;

   logic       clk;
   logic       rst;
   logic       req0, req1;
   logic [7:0] din0, din1;
   logic       key_clr0, key_clr1;
   logic       gnt0, gnt1;
   logic       crypt_en;
   logic [7:0] crypt_din, crypt_key;
   logic       crypt_v;
   logic [7:0] crypt_dout;
   logic       v0, v1;
   logic [7:0] dout0, dout1;
   logic       err;
   logic       force_v;

   int n_chk  = 0;
   int n_pass = 0;

   // Expected-value tables, indexed by negedge number within each scenario
   logic [7:0] T1_KEY   [0:9]  = '{8'h00, 8'hA5, 8'h5A, 8'hC3, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
   logic [7:0] T1_DOUT0 [0:9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99, 8'h66, 8'hFF, 8'h99, 8'h99};
   logic [7:0] T2_KEY   [0:11] = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
   logic [7:0] T2_DIN   [0:11] = '{8'h00, 8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};
   logic [7:0] T2_DOUT0 [0:11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB4, 8'hB4, 8'h4B, 8'h4B, 8'hD2, 8'hD2, 8'hD2};
   logic [7:0] T2_DOUT1 [0:11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h87, 8'h87, 8'h78, 8'h78, 8'hE1, 8'hE1};
   logic [7:0] T3_KEY   [0:10] = '{8'h00, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
   logic [7:0] T3_DOUT1 [0:10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'h55, 8'hAA};

   crypt_share_scheduler #(.LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .req1       (req1),
      .din0       (din0),
      .din1       (din1),
      .key_clr0   (key_clr0),
      .key_clr1   (key_clr1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .crypt_en   (crypt_en),
      .crypt_din  (crypt_din),
      .crypt_key  (crypt_key),
      .crypt_v    (crypt_v),
      .crypt_dout (crypt_dout),
      .v0         (v0),
      .v1         (v1),
      .dout0      (dout0),
      .dout1      (dout1),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath model: samples crypt_en, result appears LAT edges later
   logic [LAT:0] mv_q;
   logic [7:0]   md_q [0:LAT];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mv_q <= '0;
         for (int i = 0; i <= LAT; i++) md_q[i] <= '0;
      end else begin
         mv_q     <= {mv_q[LAT-1:0], crypt_en};
         md_q[0]  <= test_utils::decrypt(crypt_din, crypt_key);
         for (int i = 1; i <= LAT; i++) md_q[i] <= md_q[i-1];
      end
   end

   assign crypt_v    = mv_q[LAT] | force_v;
   assign crypt_dout = md_q[LAT];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      req0     = 1'b0;
      req1     = 1'b0;
      key_clr0 = 1'b0;
      key_clr1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      req0     = 1'b1;
      req1     = 1'b1;
      din0     = 8'h00;
      din1     = 8'h00;
      key_clr0 = 1'b0;
      key_clr1 = 1'b0;
      force_v  = 1'b0;

      // Reset state, grants blocked while in reset
      @(negedge clk);
      chk1("rst_gnt0", gnt0, 1'b0);
      chk1("rst_gnt1", gnt1, 1'b0);
      chk1("rst_en", crypt_en, 1'b0);
      chk8("rst_key", crypt_key, 8'h00);
      chk1("rst_v0", v0, 1'b0);
      chk8("rst_dout0", dout0, 8'h00);
      chk1("rst_err", err, 1'b0);
      do_reset();

      // Lone requester 0, four bytes of 3C through the key rotation
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         chk1("t1_en", crypt_en, k >= 1 && k <= 4);
         if (k >= 1) begin
            chk8("t1_key", crypt_key, T1_KEY[k]);
            chk8("t1_din", crypt_din, 8'h3C);
         end
         chk1("t1_v0", v0, k >= 5 && k <= 8);
         chk1("t1_v1", v1, 1'b0);
         chk8("t1_dout0", dout0, T1_DOUT0[k]);
         req0 = (k < 4);
         din0 = 8'h3C;
         #1;
         chk1("t1_gnt0", gnt0, k < 4);
         chk1("t1_gnt1", gnt1, 1'b0);
      end
      chk1("t1_err", err, 1'b0);

`ifndef CRYPT_SCHED_FIXED_PRIO_EN
      // Both requesting from reset: alternate grants, independent keys
      do_reset();
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         chk8("t2_key", crypt_key, T2_KEY[k]);
         chk8("t2_din", crypt_din, T2_DIN[k]);
         chk1("t2_v0", v0, k == 5 || k == 7 || k == 9);
         chk1("t2_v1", v1, k == 6 || k == 8 || k == 10);
         chk8("t2_dout0", dout0, T2_DOUT0[k]);
         chk8("t2_dout1", dout1, T2_DOUT1[k]);
         req0 = (k < 6);
         req1 = (k < 6);
         din0 = 8'h11;
         din1 = 8'h22;
         #1;
         chk1("t2_gnt0", gnt0, k < 6 && (k % 2) == 0);
         chk1("t2_gnt1", gnt1, k < 6 && (k % 2) == 1);
      end
      chk1("t2_err", err, 1'b0);
`else
      // Strict priority: requester 0 wins every conflict
      do_reset();
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         req0 = 1'b1;
         req1 = 1'b1;
         din0 = 8'h11;
         din1 = 8'h22;
         #1;
         chk1("fp_gnt0", gnt0, 1'b1);
         chk1("fp_gnt1", gnt1, 1'b0);
      end
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (6) @(negedge clk);
      chk1("fp_v1", v1, 1'b0);
      chk8("fp_dout1", dout1, 8'h00);
      chk1("fp_err", err, 1'b0);
`endif

      // Key clear on requester 1, with and without a grant
      do_reset();
      for (int k = 0; k < 11; k++) begin
         if (k > 0) @(negedge clk);
         chk1("t3_en", crypt_en, (k >= 1 && k <= 4) || k == 6);
         chk8("t3_key", crypt_key, T3_KEY[k]);
         chk1("t3_v1", v1, (k >= 5 && k <= 8) || k == 10);
         chk1("t3_v0", v0, 1'b0);
         chk8("t3_dout1", dout1, T3_DOUT1[k]);
         req1     = (k <= 3) || k == 5;
         key_clr1 = (k == 2) || (k == 4);
         din1     = 8'h0F;
         #1;
         chk1("t3_gnt1", gnt1, (k <= 3) || k == 5);
         chk1("t3_gnt0", gnt0, 1'b0);
      end
      key_clr1 = 1'b0;
      chk1("t3_err", err, 1'b0);

      // Reset mid-stream with three bytes in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req0 = 1'b1;
         din0 = 8'h77;
      end
      @(negedge clk);
      chk1("t4_inflight_en", crypt_en, 1'b1);
      rst = 1'b1;
      #1;
      chk1("t4_en", crypt_en, 1'b0);
      chk8("t4_din", crypt_din, 8'h00);
      chk8("t4_key", crypt_key, 8'h00);
      chk1("t4_v0", v0, 1'b0);
      chk1("t4_v1", v1, 1'b0);
      chk8("t4_dout0", dout0, 8'h00);
      chk8("t4_dout1", dout1, 8'h00);
      chk1("t4_err", err, 1'b0);
      chk1("t4_gnt0", gnt0, 1'b0);
      @(negedge clk);
      rst  = 1'b0;
      req0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk1("t4_post_v0", v0, 1'b0);
         chk1("t4_post_v1", v1, 1'b0);
         chk1("t4_post_err", err, 1'b0);
      end

      // Spurious crypt_v with nothing in flight sets a sticky error
      force_v = 1'b1;
      @(negedge clk);
      force_v = 1'b0;
      chk1("t5_err_set", err, 1'b1);
      chk1("t5_v0", v0, 1'b0);
      chk1("t5_v1", v1, 1'b0);
      repeat (3) @(negedge clk);
      chk1("t5_err_hold", err, 1'b1);
      rst = 1'b1;
      #1;
      chk1("t5_err_clr", err, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
